rshift_deser: RTL

RSHIFT_DESER -- requirements
Module: rshift_deser

---
 rtl/rshift_deser.sv | 105 ++++++++++
 1 files changed

// File: rtl/rshift_deser.sv
// rshift_deser -- MSB-first serial-to-parallel converter with a one-word
// output register and a valid/ready handshake.
//
// Bits are shifted in on cycles where sin_valid is high. When the WIDTH-th
// bit arrives, the completed word moves into the output register on that
// same edge. The input is never stalled. If the output register is still
// occupied and not being accepted, the new word is dropped and a sticky
// overrun flag is raised.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset, highest priority
//   sin        in   serial data bit
//   sin_valid  in   qualifies sin for this cycle
//   op_ready   in   downstream accepts op while op_valid is high
//   err_clr    in   clears the sticky overrun flag
//   op         out  assembled parallel word (WIDTH bits)
//   op_valid   out  op holds a word that has not been accepted yet
//   bit_cnt    out  number of bits currently held in the shift register
//   busy       out  high while bit_cnt != 0
//   overrun    out  sticky, a completed word was dropped
module rshift_deser #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sin,
  input  logic                       sin_valid,
  input  logic                       op_ready,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           op,
  output logic                       op_valid,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       busy,
  output logic                       overrun
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  // COLLECT: the bit taken this cycle (if any) does not finish a word.
  // COMPLETE: the WIDTH-th bit is being sampled on the coming edge.
  typedef enum logic {
    COLLECT  = 1'b0,
    COMPLETE = 1'b1
  } state_t;

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word_next;
  state_t           state_next;
  logic             accept;
  logic             out_free;

  always_comb begin
    word_next  = {shreg[WIDTH-2:0], sin};
    state_next = COLLECT;
    if (sin_valid && (bit_cnt == LAST_IDX)) begin
      state_next = COMPLETE;
    end
    accept   = op_valid && op_ready;
    // The output register can take a new word if it is empty or its
    // current word is being accepted on this same edge.
    out_free = !op_valid || op_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      op       <= '0;
      op_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (sin_valid) begin
        shreg <= word_next;
        if (state_next == COMPLETE) begin
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      // Output register: a completed word loads if there is room,
      // otherwise the old word is kept and the new one is lost.
      if (state_next == COMPLETE) begin
        if (out_free) begin
          op       <= word_next;
          op_valid <= 1'b1;
        end
      end else if (accept) begin
        op_valid <= 1'b0;
      end

      // A fresh overrun wins over a clear issued in the same cycle.
      if ((state_next == COMPLETE) && !out_free) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign busy = (bit_cnt != '0);

endmodule
